// File: rtl/intersection_phase_timer.sv
// rtl/intersection_phase_timer.sv - NS/EW traffic phase sequencer with 1 s countdown.
// Fixed green/yellow/all-red cycle, pedestrian shortening and flashing-yellow service mode.
module intersection_phase_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int GREEN_S  = 30,
  parameter int YELLOW_S = 4,
  parameter int ALLRED_S = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       service_en_i,
  input  logic       ped_req_i,
  output logic [2:0] ns_light_o,
  output logic [2:0] ew_light_o,
  output logic [7:0] counter_o,
  output logic       service_n_o,
  output logic       tick_o
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] PED_CNT = 8'd5;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_DARK   = 3'b000;

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    ALLRED_A,
    EW_GREEN,
    EW_YELLOW,
    ALLRED_B,
    SERVICE
  } state_t;

  state_t        state_q, state_d;
  state_t        next_phase;
  logic [7:0]    cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ped_q, ped_d;
  logic          flash_q, flash_d;
  logic [2:0]    ns_q, ns_d;
  logic [2:0]    ew_q, ew_d;
  logic          svc_n_q, svc_n_d;
  logic          tick_q, tick_d;

  logic tick;
  logic green;
  logic ped_pend;
  logic shorten;

  function automatic logic [7:0] phase_len(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   phase_len = 8'(GREEN_S);
      NS_YELLOW, EW_YELLOW: phase_len = 8'(YELLOW_S);
      default:              phase_len = 8'(ALLRED_S);
    endcase
  endfunction

  always_comb begin
    case (state_q)
      NS_GREEN:  next_phase = NS_YELLOW;
      NS_YELLOW: next_phase = ALLRED_A;
      ALLRED_A:  next_phase = EW_GREEN;
      EW_GREEN:  next_phase = EW_YELLOW;
      EW_YELLOW: next_phase = ALLRED_B;
      default:   next_phase = NS_GREEN;
    endcase
  end

  // The request pulse counts as pending on the very edge it is sampled.
  assign tick     = (presc_q == PRESC_LAST);
  assign green    = (state_q == NS_GREEN) || (state_q == EW_GREEN);
  assign ped_pend = ped_q | ped_req_i;
  assign shorten  = green && ped_pend && (cnt_q > PED_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    ped_d   = ped_pend;
    flash_d = flash_q;

    if (service_en_i) begin
      state_d = SERVICE;
      cnt_d   = 8'd0;
      ped_d   = 1'b0;
      if (state_q != SERVICE) begin
        flash_d = 1'b1;
      end else if (tick) begin
        flash_d = ~flash_q;
      end
    end else if (state_q == SERVICE) begin
      state_d = ALLRED_B;
      cnt_d   = 8'(ALLRED_S);
      presc_d = '0;
      ped_d   = 1'b0;
      flash_d = 1'b1;
    end else begin
      if (green && ped_pend) begin
        ped_d = 1'b0;
      end
      if (shorten) begin
        cnt_d = PED_CNT;
      end else if (tick) begin
        if (cnt_q > 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = next_phase;
          cnt_d   = phase_len(next_phase);
        end
      end
    end
  end

  // Outputs decode the next state so they land on the same edge as the state register.
  always_comb begin
    ns_d    = LIGHT_RED;
    ew_d    = LIGHT_RED;
    svc_n_d = 1'b1;
    tick_d  = (presc_d == PRESC_LAST);
    case (state_d)
      NS_GREEN:  ns_d = LIGHT_GREEN;
      NS_YELLOW: ns_d = LIGHT_YELLOW;
      EW_GREEN:  ew_d = LIGHT_GREEN;
      EW_YELLOW: ew_d = LIGHT_YELLOW;
      SERVICE: begin
        ns_d    = flash_d ? LIGHT_YELLOW : LIGHT_DARK;
        ew_d    = flash_d ? LIGHT_YELLOW : LIGHT_DARK;
        svc_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ALLRED_B;
      cnt_q   <= 8'(ALLRED_S);
      presc_q <= '0;
      ped_q   <= 1'b0;
      flash_q <= 1'b1;
      ns_q    <= LIGHT_RED;
      ew_q    <= LIGHT_RED;
      svc_n_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      ped_q   <= ped_d;
      flash_q <= flash_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      svc_n_q <= svc_n_d;
      tick_q  <= tick_d;
    end
  end

  assign ns_light_o  = ns_q;
  assign ew_light_o  = ew_q;
  assign counter_o   = cnt_q;
  assign service_n_o = svc_n_q;
  assign tick_o      = tick_q;

endmodule

// File: tb/tb_intersection_phase_timer.sv
// tb/tb_intersection_phase_timer.sv - bench for intersection_phase_timer.
// Directed test-plan scenarios plus random traffic against a phase-table reference model.
module tb_intersection_phase_timer;

  localparam int TD = 4;
  localparam int GS = 10;
  localparam int YS = 3;
  localparam int AS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       svc = 1'b0;
  logic       ped = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [7:0] counter;
  logic       service_n;
  logic       tick;

  int n_checks = 0;
  int n_errors = 0;

  intersection_phase_timer #(
    .TICK_DIV(TD),
    .GREEN_S (GS),
    .YELLOW_S(YS),
    .ALLRED_S(AS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .service_en_i(svc),
    .ped_req_i   (ped),
    .ns_light_o  (ns_light),
    .ew_light_o  (ew_light),
    .counter_o   (counter),
    .service_n_o (service_n),
    .tick_o      (tick)
  );

  always #5 clk = ~clk;

  // Phase table: index 0..5 = NS green, NS yellow, all-red, EW green, EW yellow, all-red.
  int dur_tab[6] = '{GS, YS, AS, GS, YS, AS};
  int ns_tab[6]  = '{1, 2, 4, 4, 4, 4};
  int ew_tab[6]  = '{4, 4, 4, 1, 2, 4};

  bit m_valid = 0;
  bit m_svc   = 0;
  int m_phase = 5;
  int m_rem   = AS;
  int m_sec   = 0;
  bit m_ped   = 0;
  bit m_flash = 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit p);
    bit sec_end;
    bit pend;
    sec_end = (m_sec == TD - 1);
    if (r) begin
      m_valid = 1; m_svc = 0; m_phase = 5; m_rem = AS; m_sec = 0; m_ped = 0; m_flash = 1;
      return;
    end
    if (s) begin
      if (!m_svc) m_flash = 1;
      else if (sec_end) m_flash = !m_flash;
      m_svc = 1;
      m_ped = 0;
      m_sec = sec_end ? 0 : m_sec + 1;
    end else if (m_svc) begin
      m_svc = 0; m_phase = 5; m_rem = AS; m_sec = 0; m_ped = 0; m_flash = 1;
    end else begin
      pend = m_ped || p;
      if ((m_phase % 3 == 0) && pend) begin
        m_ped = 0;
        if (m_rem > 5) begin
          m_rem = 5;
          sec_end = 0;
        end
      end else begin
        m_ped = pend;
      end
      if (sec_end) begin
        if (m_rem > 1) m_rem--;
        else begin
          m_phase = (m_phase + 1) % 6;
          m_rem = dur_tab[m_phase];
        end
      end
      m_sec = (m_sec == TD - 1) ? 0 : m_sec + 1;
    end
  endtask

  task automatic compare_model();
    int e_ns, e_ew;
    if (!m_valid) return;
    e_ns = m_svc ? (m_flash ? 2 : 0) : ns_tab[m_phase];
    e_ew = m_svc ? (m_flash ? 2 : 0) : ew_tab[m_phase];
    check_val("m_ns", ns_light, e_ns);
    check_val("m_ew", ew_light, e_ew);
    check_val("m_cnt", counter, m_svc ? 0 : m_rem);
    check_val("m_svc_n", service_n, m_svc ? 0 : 1);
    check_val("m_tick", tick, (m_sec == TD - 1) ? 1 : 0);
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic step(input bit r, input bit s, input bit p);
    rst = r; svc = s; ped = p;
    @(posedge clk);
    model_step(r, s, p);
    @(negedge clk);
    ped = 1'b0;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    int budget;
    bit rs, sv;
    @(negedge clk);

    step(1, 0, 0);
    step(1, 0, 0);
    check_val("rst_ns", ns_light, 4);
    check_val("rst_ew", ew_light, 4);
    check_val("rst_cnt", counter, AS);
    check_val("rst_svc_n", service_n, 1);
    check_val("rst_tick", tick, 0);

    idle(7);
    check_val("pre_green_ns", ns_light, 4);
    idle(1);
    check_val("green_ns", ns_light, 1);
    check_val("green_ew", ew_light, 4);
    check_val("green_cnt", counter, GS);

    idle(40);
    check_val("nsy_ns", ns_light, 2);
    check_val("nsy_cnt", counter, YS);
    idle(80);
    check_val("cycle_ns", ns_light, 1);
    check_val("cycle_cnt", counter, GS);

    // Pedestrian request at EW green with 9 s left, just after the decrement.
    budget = 0;
    while (!(ew_light == 1 && counter == 9 && tick == 0) && budget < 300) begin
      idle(1); budget++;
    end
    check_val("wait_ew9", budget < 300, 1);
    step(0, 0, 1);
    check_val("ped9_cnt", counter, 5);

    // Pedestrian request together with a tick at 8 s left.
    budget = 0;
    while (!(ew_light == 1 && counter == 8 && tick == 1) && budget < 300) begin
      idle(1); budget++;
    end
    check_val("wait_ew8_tick", budget < 300, 1);
    step(0, 0, 1);
    check_val("ped_tick_cnt", counter, 5);

    // Request at 4 s left: no change, and flag must not carry into the next green.
    budget = 0;
    while (!(ns_light == 1 && counter == 4 && tick == 0) && budget < 300) begin
      idle(1); budget++;
    end
    check_val("wait_ns4", budget < 300, 1);
    step(0, 0, 1);
    check_val("ped4_cnt", counter, 4);
    idle(60);

    // Service mode entry and exit mid NS green.
    budget = 0;
    while (!(ns_light == 1 && counter == 7) && budget < 300) begin
      idle(1); budget++;
    end
    check_val("wait_ns7", budget < 300, 1);
    step(0, 1, 0);
    check_val("svc_n", service_n, 0);
    check_val("svc_cnt", counter, 0);
    check_val("svc_ns", ns_light, 2);
    check_val("svc_ew", ew_light, 2);
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    step(0, 0, 0);
    check_val("exit_ns", ns_light, 4);
    check_val("exit_ew", ew_light, 4);
    check_val("exit_cnt", counter, AS);
    check_val("exit_svc_n", service_n, 1);
    idle(8);
    check_val("exit_green_ns", ns_light, 1);
    check_val("exit_green_cnt", counter, GS);

    // Reset in NS yellow with a pedestrian request still pending.
    budget = 0;
    while (!(ns_light == 2) && budget < 300) begin
      idle(1); budget++;
    end
    check_val("wait_nsy", budget < 300, 1);
    step(0, 0, 1);
    step(1, 0, 0);
    check_val("mid_rst_cnt", counter, AS);
    check_val("mid_rst_ns", ns_light, 4);
    idle(8);
    check_val("mid_rst_green_cnt", counter, GS);
    idle(4);
    check_val("no_short_cnt", counter, GS - 1);

    // Random traffic.
    sv = 0;
    for (int i = 0; i < 4000; i++) begin
      rs = ($urandom_range(0, 599) == 0);
      if (sv) sv = ($urandom_range(0, 24) != 0);
      else sv = ($urandom_range(0, 299) == 0);
      step(rs, sv, $urandom_range(0, 14) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
